ysyx_23060229_shift_arbiter: RTL and testbench
==============================================

# ysyx_23060229_shift_arbiter

Two-requester arbiter and sequencer for the shared 32-bit shift unit. It accepts shift requests from two independent clients over valid/ready handshakes and grants them in round-robin order. It computes SLL, SRL or SRA in one cycle and holds each result in a registered response slot until the owning client accepts it. The block sits between the execute-stage clients (ALU port 0, auxiliary/CSR-side port 1) and the shift datapath, so only one shifter instance is built.

## Interface
- RR_INIT, 0, requester that holds priority after reset (0 or 1)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port-0 request valid
- req0_ready  out  1  port-0 request accepted this cycle when high with req0_valid
- req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through (result = src1)
- req0_src1  in  32  operand to shift
- req0_shamt  in  5  shift amount, 0..31
- req1_valid / req1_ready / req1_op / req1_src1 / req1_shamt: same as port 0, for port 1
- rsp0_valid  out  1  port-0 result valid
- rsp0_ready  in  1  port-0 consumer accepts result
- rsp0_data  out  32  port-0 result
- rsp1_valid / rsp1_ready / rsp1_data: same as port 0, for port 1

## Operation
- FSM states: IDLE (no result held) and BUSY (one result held, owner tagged).
- Slot is free when the FSM is in IDLE, or in BUSY when the owner's rspN_ready = 1 in the same cycle.
- Arbitration, evaluated combinationally when the slot is free:
  - One valid requester: it wins.
  - Both valid: the requester named by the priority pointer wins.
  - Only the winner sees reqN_ready = 1; the loser's ready is 0.
  - reqN_ready may depend combinationally on reqN_valid, the other port's valid and the owner's rspN_ready; clients must not make valid depend on ready.
- On an accepted request (valid and ready):
  - Result is computed from the winner's op/src1/shamt and registered into the result slot.
  - Owner is set to the winner.
  - Priority pointer is set to the other port.
  - FSM goes to BUSY, or stays in BUSY on a back-to-back accept.
- Priority pointer changes only on an accepted request.
- Shift rules:
  - SLL: zeros fill from the right.
  - SRL: zeros fill from the left.
  - SRA: src1[31] fills from the left.
  - shamt = 0 returns src1 unchanged for every op, SRA included. No 32-bit shift-by-32 artefact is allowed.
- rspN_valid = 1 only when in BUSY and owner = N; the other port's rsp_valid stays 0.
- rspN_data is the registered result while rspN_valid is high. It is zero when not owner, or drives the slot value; it is don't-care when valid is low, but must be stable while valid is high.
- Owner accepts (rsp_valid and rsp_ready) with no request accepted that cycle: FSM returns to IDLE.
- The response is held indefinitely while rsp_ready = 0. A new request is not accepted during that time.

## Timing
- Reset values:
  - FSM = IDLE.
  - rsp0_valid = rsp1_valid = 0.
  - Result slot = 0x00000000.
  - Owner = 0.
  - Priority pointer = RR_INIT.
  - req0_ready and req1_ready are 0 during the reset cycle.
- Latency: a request accepted at edge k produces rspN_valid = 1 from edge k+1.
- Throughput: one operation per cycle when each result is consumed in the cycle it appears (accept and new grant in the same cycle).
- Simultaneous accept of the response and a new request from the same port: rsp stays valid next cycle with the new data.
- Simultaneous accept of the response on port 0 and a request grant to port 1: rsp0_valid falls and rsp1_valid rises at the next edge.
- Reset mid-operation: any held result is discarded, no response is issued for it, and the pointer reloads RR_INIT.

## Test plan
- Reset, then port 0 sends SRA src1=0x80000000 shamt=4 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_data=0xF8000000; rsp1_valid stays 0.
- Shift-amount boundaries on port 1:
  - SRA 0x80000000 shamt=0 -> 0x80000000.
  - SRA 0x7FFFFFFF shamt=31 -> 0x00000000.
  - SRL 0x80000000 shamt=31 -> 0x00000001.
  - SLL 0x00000001 shamt=31 -> 0x80000000.
  - op=11 src1=0x12345678 -> 0x12345678.
- Both ports valid every cycle with rsp ready held at 1, RR_INIT=0 -> grants alternate 0,1,0,1; a result is issued every cycle; each port gets exactly half the grants.
- Port 0 response held with rsp0_ready=0 for 5 cycles while port 1 is valid -> req1_ready=0 throughout and rsp0_data is stable. Then rsp0_ready=1 -> port 1 is granted in that same cycle and rsp1_valid=1 the next cycle.
- Assert reset for one cycle while rsp1_valid=1 -> next cycle both rsp valids are 0 and no stale response appears. With both ports then valid and RR_INIT=1, port 1 wins first.
- Back-to-back on port 0: SLL 0x0000000F by 4, then SRL 0xF0000000 by 28, rsp0_ready=1 -> rsp0_data is 0x000000F0, then 0x0000000F on consecutive cycles, with rsp0_valid continuously high.

Source files
------------

// File: rtl/ysyx_23060229_shift_arbiter_if.sv
// Request/response bundle between two execute-stage clients and the shared shift unit.
// master = client side, slave = arbiter side.
interface ysyx_23060229_shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_src1;
  logic [4:0]  req0_shamt;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_src1;
  logic [4:0]  req1_shamt;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_src1, req0_shamt,
    output req1_valid, req1_op, req1_src1, req1_shamt,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_src1, req0_shamt,
    input  req1_valid, req1_op, req1_src1, req1_shamt,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/ysyx_23060229_shift_arbiter.sv
// Round-robin two-port arbiter in front of a single 32-bit shifter (SLL/SRL/SRA/pass),
// with one registered result slot tagged by owner.
module ysyx_23060229_shift_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input logic                           clock,
  input logic                           reset,
  ysyx_23060229_shift_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic [31:0] result_q, result_d;

  logic        owner_rsp_ready;
  logic        rsp_fire;
  logic        slot_free;
  logic        grant0, grant1;
  logic        accept;
  logic [1:0]  sel_op;
  logic [31:0] sel_src;
  logic [4:0]  sel_shamt;
  logic [31:0] shift_res;

  // A 5-bit amount never reaches 32, so shamt=0 naturally returns src unchanged.
  function automatic logic [31:0] do_shift(input logic [1:0] op, input logic [31:0] src,
                                           input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      2'b00:   r = src << sh;
      2'b01:   r = src >> sh;
      2'b10:   r = $unsigned($signed(src) >>> sh);
      default: r = src;
    endcase
    return r;
  endfunction

  always_comb begin
    owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    rsp_fire        = (state_q == BUSY) && owner_rsp_ready;
    slot_free       = !reset && ((state_q == IDLE) || owner_rsp_ready);

    grant0 = slot_free && bus.req0_valid && (!bus.req1_valid || (prio_q == 1'b0));
    grant1 = slot_free && bus.req1_valid && (!bus.req0_valid || (prio_q == 1'b1));
    accept = grant0 || grant1;

    sel_op    = grant1 ? bus.req1_op    : bus.req0_op;
    sel_src   = grant1 ? bus.req1_src1  : bus.req0_src1;
    sel_shamt = grant1 ? bus.req1_shamt : bus.req0_shamt;
    shift_res = do_shift(sel_op, sel_src, sel_shamt);

    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    result_d = result_q;

    if (accept) begin
      state_d  = BUSY;
      owner_d  = grant1;
      prio_d   = ~grant1;
      result_d = shift_res;
    end else if (rsp_fire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      prio_q   <= RR_INIT;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      result_q <= result_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign bus.rsp0_valid = (state_q == BUSY) && (owner_q == 1'b0);
  assign bus.rsp1_valid = (state_q == BUSY) && (owner_q == 1'b1);
  assign bus.rsp0_data  = bus.rsp0_valid ? result_q : '0;
  assign bus.rsp1_data  = bus.rsp1_valid ? result_q : '0;

endmodule

// File: tb/tb_ysyx_23060229_shift_arbiter.sv
// Directed bench: instance A (RR_INIT=0) covers shifts, round-robin, back-pressure and
// back-to-back; instance B (RR_INIT=1) covers mid-operation reset and pointer reload.
module tb_ysyx_23060229_shift_arbiter;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ysyx_23060229_shift_arbiter_if bus_a ();
  ysyx_23060229_shift_arbiter_if bus_b ();

  ysyx_23060229_shift_arbiter #(.RR_INIT(1'b0)) u_dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  ysyx_23060229_shift_arbiter #(.RR_INIT(1'b1)) u_dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a0(input logic v, input logic [1:0] op, input logic [31:0] s, input logic [4:0] sh);
    bus_a.req0_valid = v; bus_a.req0_op = op; bus_a.req0_src1 = s; bus_a.req0_shamt = sh;
  endtask

  task automatic drv_a1(input logic v, input logic [1:0] op, input logic [31:0] s, input logic [4:0] sh);
    bus_a.req1_valid = v; bus_a.req1_op = op; bus_a.req1_src1 = s; bus_a.req1_shamt = sh;
  endtask

  logic [1:0]  t_op  [5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b11};
  logic [31:0] t_src [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678};
  logic [4:0]  t_sh  [5] = '{5'd0, 5'd31, 5'd31, 5'd31, 5'd7};
  logic [31:0] t_exp [5] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678};

  initial begin
    int unsigned cnt0, cnt1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drv_a0(1'b0, 2'b00, '0, '0);
    drv_a1(1'b0, 2'b00, '0, '0);
    bus_a.rsp0_ready = 1'b1; bus_a.rsp1_ready = 1'b1;
    bus_b.req0_valid = 1'b0; bus_b.req0_op = 2'b00; bus_b.req0_src1 = '0; bus_b.req0_shamt = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_op = 2'b00; bus_b.req1_src1 = '0; bus_b.req1_shamt = '0;
    bus_b.rsp0_ready = 1'b1; bus_b.rsp1_ready = 1'b1;

    // Reset cycle: ready must stay low even with valid requests.
    tick();
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", {31'b0, bus_a.req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'b0, bus_a.req1_ready}, 32'd0);
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk("rst_rsp0_valid", {31'b0, bus_a.rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, bus_a.rsp1_valid}, 32'd0);

    // First transaction: SRA on port 0.
    drv_a0(1'b1, 2'b10, 32'h8000_0000, 5'd4);
    #1;
    chk("t1_req0_ready", {31'b0, bus_a.req0_ready}, 32'd1);
    tick();
    bus_a.req0_valid = 1'b0;
    chk("t1_rsp0_valid", {31'b0, bus_a.rsp0_valid}, 32'd1);
    chk("t1_rsp0_data", bus_a.rsp0_data, 32'hF800_0000);
    chk("t1_rsp1_valid", {31'b0, bus_a.rsp1_valid}, 32'd0);
    tick();

    // Shift-amount boundaries on port 1, back-to-back.
    for (int i = 0; i < 5; i++) begin
      drv_a1(1'b1, t_op[i], t_src[i], t_sh[i]);
      #1;
      chk($sformatf("bnd%0d_ready", i), {31'b0, bus_a.req1_ready}, 32'd1);
      tick();
      chk($sformatf("bnd%0d_valid", i), {31'b0, bus_a.rsp1_valid}, 32'd1);
      chk($sformatf("bnd%0d_data", i), bus_a.rsp1_data, t_exp[i]);
    end
    bus_a.req1_valid = 1'b0;
    tick();

    // Round robin: last grant went to port 1, so port 0 leads.
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      drv_a0(1'b1, 2'b00, 32'h0000_0001, i[4:0]);
      drv_a1(1'b1, 2'b01, 32'h8000_0000, i[4:0]);
      #1;
      if (bus_a.req0_ready) cnt0++;
      if (bus_a.req1_ready) cnt1++;
      chk($sformatf("rr%0d_ready0", i), {31'b0, bus_a.req0_ready}, {31'b0, (i % 2) == 0});
      chk($sformatf("rr%0d_ready1", i), {31'b0, bus_a.req1_ready}, {31'b0, (i % 2) == 1});
      tick();
      if ((i % 2) == 0) begin
        chk($sformatf("rr%0d_v0", i), {31'b0, bus_a.rsp0_valid}, 32'd1);
        chk($sformatf("rr%0d_d0", i), bus_a.rsp0_data, 32'h0000_0001 << i);
      end else begin
        chk($sformatf("rr%0d_v1", i), {31'b0, bus_a.rsp1_valid}, 32'd1);
        chk($sformatf("rr%0d_d1", i), bus_a.rsp1_data, 32'h8000_0000 >> i);
      end
    end
    chk("rr_cnt0", cnt0, 32'd4);
    chk("rr_cnt1", cnt1, 32'd4);
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    tick();

    // Back-pressure on port 0 blocks port 1.
    bus_a.rsp0_ready = 1'b0;
    drv_a0(1'b1, 2'b00, 32'h0000_000F, 5'd8);
    tick();
    bus_a.req0_valid = 1'b0;
    drv_a1(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd16);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold%0d_ready1", i), {31'b0, bus_a.req1_ready}, 32'd0);
      chk($sformatf("hold%0d_v0", i), {31'b0, bus_a.rsp0_valid}, 32'd1);
      chk($sformatf("hold%0d_d0", i), bus_a.rsp0_data, 32'h0000_0F00);
      tick();
    end
    bus_a.rsp0_ready = 1'b1;
    #1;
    chk("rel_ready1", {31'b0, bus_a.req1_ready}, 32'd1);
    tick();
    bus_a.req1_valid = 1'b0;
    chk("rel_v0", {31'b0, bus_a.rsp0_valid}, 32'd0);
    chk("rel_v1", {31'b0, bus_a.rsp1_valid}, 32'd1);
    chk("rel_d1", bus_a.rsp1_data, 32'h0000_FFFF);
    tick();

    // Back-to-back on port 0.
    drv_a0(1'b1, 2'b00, 32'h0000_000F, 5'd4);
    tick();
    chk("b2b0_v", {31'b0, bus_a.rsp0_valid}, 32'd1);
    chk("b2b0_d", bus_a.rsp0_data, 32'h0000_00F0);
    drv_a0(1'b1, 2'b01, 32'hF000_0000, 5'd28);
    #1;
    chk("b2b1_ready", {31'b0, bus_a.req0_ready}, 32'd1);
    tick();
    bus_a.req0_valid = 1'b0;
    chk("b2b1_v", {31'b0, bus_a.rsp0_valid}, 32'd1);
    chk("b2b1_d", bus_a.rsp0_data, 32'h0000_000F);
    tick();
    chk("b2b_idle", {31'b0, bus_a.rsp0_valid}, 32'd0);

    // Instance B: port 1 first (RR_INIT=1), then reset while its result is held.
    bus_b.req1_valid = 1'b1; bus_b.req1_op = 2'b00; bus_b.req1_src1 = 32'h0000_0003; bus_b.req1_shamt = 5'd1;
    tick();
    bus_b.req1_valid = 1'b0;
    bus_b.rsp1_ready = 1'b0;
    chk("b_pre_v1", {31'b0, bus_b.rsp1_valid}, 32'd1);
    chk("b_pre_d1", bus_b.rsp1_data, 32'h0000_0006);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    bus_b.rsp1_ready = 1'b1;
    chk("b_rst_v0", {31'b0, bus_b.rsp0_valid}, 32'd0);
    chk("b_rst_v1", {31'b0, bus_b.rsp1_valid}, 32'd0);
    tick();
    chk("b_stale_v1", {31'b0, bus_b.rsp1_valid}, 32'd0);
    bus_b.req0_valid = 1'b1; bus_b.req0_op = 2'b11; bus_b.req0_src1 = 32'hAAAA_0000; bus_b.req0_shamt = 5'd0;
    bus_b.req1_valid = 1'b1; bus_b.req1_op = 2'b11; bus_b.req1_src1 = 32'h0000_5555; bus_b.req1_shamt = 5'd0;
    #1;
    chk("b_ptr_ready1", {31'b0, bus_b.req1_ready}, 32'd1);
    chk("b_ptr_ready0", {31'b0, bus_b.req0_ready}, 32'd0);
    tick();
    bus_b.req0_valid = 1'b0;
    bus_b.req1_valid = 1'b0;
    chk("b_ptr_v1", {31'b0, bus_b.rsp1_valid}, 32'd1);
    chk("b_ptr_d1", bus_b.rsp1_data, 32'h0000_5555);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
